uparc_muldiv_engine: RTL and testbench



---
 rtl/uparc_muldiv_engine.sv | 217 +++++++++++++++++++++
 tb/tb_uparc_muldiv_engine.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uparc_muldiv_engine.sv
// uparc_muldiv_engine
// Iterative integer multiply/divide engine behind the HI/LO unit.
// Retires STEP bits per RUN cycle (N = WIDTH/STEP iterations), then a FIX
// cycle applies sign correction and registers the {HI,LO} result.
//
// Ports:
//   clk, rst         clock, synchronous active-high reset
//   i_start          start request, accepted only while o_ready=1
//   i_op             00 MULU, 01 MUL, 10 DIVU, 11 DIV
//   i_a, i_b         multiplicand/dividend, multiplier/divisor
//   i_abort          cancel the operation in flight (RUN or FIX)
//   o_ready          engine idle
//   o_done           one-cycle pulse, result registers updated
//   o_hi, o_lo       MUL: product halves; DIV: remainder, quotient
//   o_dbz            last completed op was a divide by zero
//
// Build option:
//   UPARC_MULDIV_EARLY_OUT_EN  multiply finishes once the remaining multiplier
//                              bits are zero; divide by zero skips RUN.
//                              Results are identical, only latency changes.
module uparc_muldiv_engine #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned STEP  = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_start,
    input  logic [1:0]       i_op,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    input  logic             i_abort,
    output logic             o_ready,
    output logic             o_done,
    output logic [WIDTH-1:0] o_hi,
    output logic [WIDTH-1:0] o_lo,
    output logic             o_dbz
);

    localparam int unsigned N  = WIDTH / STEP;
    localparam int unsigned CW = (N > 1) ? $clog2(N) : 1;
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

    state_t state, state_nx;
    logic   load, step_en, fix_en;

    logic [CW-1:0]        cnt;
    logic                 div_op;
    logic                 neg_res;
    logic                 neg_rem;
    logic                 dbz_op;
    logic [WIDTH-1:0]     a_raw;
    logic [WIDTH-1:0]     mag_b;
    logic [2*WIDTH-1:0]   mcand;
    // Multiply: running product. Divide: {remainder, dividend/quotient}.
    logic [2*WIDTH-1:0]   acc;

    logic                 sign_a, sign_b, b_zero;
    logic [WIDTH-1:0]     mag_a, mag_b_in;

    logic [2*WIDTH-1:0]   mul_acc, mul_mc;
    logic [WIDTH-1:0]     mul_b;
    logic [WIDTH-1:0]     div_rem, div_quo;
    logic [WIDTH:0]       div_sh;

    logic [2*WIDTH-1:0]   prod_fix;
    logic [WIDTH-1:0]     quo_fix, rem_fix;

    // Operand conditioning for the load cycle.
    always_comb begin
        sign_a   = i_op[0] & i_a[WIDTH-1];
        sign_b   = i_op[0] & i_b[WIDTH-1];
        mag_a    = sign_a ? -i_a : i_a;
        mag_b_in = sign_b ? -i_b : i_b;
        b_zero   = (i_b == '0);
    end

    // One RUN iteration: STEP shift-add steps for multiply, STEP chained
    // restoring steps for divide. The multiplicand shifts left instead of the
    // product shifting right so an early exit leaves a complete product.
    always_comb begin
        mul_acc = acc;
        mul_mc  = mcand;
        mul_b   = mag_b;
        div_rem = acc[2*WIDTH-1:WIDTH];
        div_quo = acc[WIDTH-1:0];
        div_sh  = '0;
        for (int unsigned i = 0; i < STEP; i++) begin
            if (mul_b[0]) begin
                mul_acc = mul_acc + mul_mc;
            end
            mul_mc  = mul_mc << 1;
            mul_b   = mul_b >> 1;

            div_sh  = {div_rem, div_quo[WIDTH-1]};
            div_quo = {div_quo[WIDTH-2:0], 1'b0};
            if (div_sh >= {1'b0, mag_b}) begin
                div_sh     = div_sh - {1'b0, mag_b};
                div_quo[0] = 1'b1;
            end
            div_rem = div_sh[WIDTH-1:0];
        end
    end

    // Sign correction. Most-negative / -1 wraps to most-negative naturally.
    always_comb begin
        prod_fix = neg_res ? -acc : acc;
        quo_fix  = neg_res ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
        rem_fix  = neg_rem ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        load     = 1'b0;
        step_en  = 1'b0;
        fix_en   = 1'b0;
        o_ready  = (state == IDLE);
        case (state)
            IDLE: begin
                if (i_start && !i_abort) begin
                    load = 1'b1;
`ifdef UPARC_MULDIV_EARLY_OUT_EN
                    state_nx = (i_op[1] && b_zero) ? FIX : RUN;
`else
                    state_nx = RUN;
`endif
                end
            end
            RUN: begin
                if (i_abort) begin
                    state_nx = IDLE;
                end else begin
                    step_en = 1'b1;
                    if (cnt == LAST) begin
                        state_nx = FIX;
                    end
`ifdef UPARC_MULDIV_EARLY_OUT_EN
                    else if (!div_op && mul_b == '0) begin
                        state_nx = FIX;
                    end
`endif
                end
            end
            FIX: begin
                state_nx = IDLE;
                fix_en   = !i_abort;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt     <= '0;
            div_op  <= 1'b0;
            neg_res <= 1'b0;
            neg_rem <= 1'b0;
            dbz_op  <= 1'b0;
            a_raw   <= '0;
            mag_b   <= '0;
            mcand   <= '0;
            acc     <= '0;
            o_done  <= 1'b0;
            o_hi    <= '0;
            o_lo    <= '0;
            o_dbz   <= 1'b0;
        end else begin
            o_done <= fix_en;
            if (load) begin
                cnt     <= '0;
                div_op  <= i_op[1];
                neg_res <= sign_a ^ sign_b;
                neg_rem <= sign_a;
                dbz_op  <= i_op[1] & b_zero;
                a_raw   <= i_a;
                mag_b   <= mag_b_in;
                mcand   <= {{WIDTH{1'b0}}, mag_a};
                acc     <= i_op[1] ? {{WIDTH{1'b0}}, mag_a} : '0;
            end
            if (step_en) begin
                cnt <= cnt + CW'(1);
                if (div_op) begin
                    acc <= {div_rem, div_quo};
                end else begin
                    acc   <= mul_acc;
                    mcand <= mul_mc;
                    mag_b <= mul_b;
                end
            end
            if (fix_en) begin
                if (!div_op) begin
                    o_hi  <= prod_fix[2*WIDTH-1:WIDTH];
                    o_lo  <= prod_fix[WIDTH-1:0];
                    o_dbz <= 1'b0;
                end else if (dbz_op) begin
                    o_hi  <= a_raw;
                    o_lo  <= '1;
                    o_dbz <= 1'b1;
                end else begin
                    o_hi  <= rem_fix;
                    o_lo  <= quo_fix;
                    o_dbz <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_uparc_muldiv_engine.sv
// Testbench for uparc_muldiv_engine: two instances (STEP=1 and STEP=4,
// WIDTH=32) share operands; results and done timing are predicted from a
// 64-bit arithmetic model and checked from a scoreboard as o_done appears.
module tb_uparc_muldiv_engine;

    localparam int unsigned W = 32;

    logic          clk = 1'b0;
    logic          rst;
    logic          start1, start4, abort;
    logic [1:0]    op;
    logic [W-1:0]  a, b;
    logic          ready1, done1, dbz1, ready4, done4, dbz4;
    logic [W-1:0]  hi1, lo1, hi4, lo4;

    always #5 clk = ~clk;

    uparc_muldiv_engine #(.WIDTH(W), .STEP(1)) dut1 (
        .clk(clk), .rst(rst), .i_start(start1), .i_op(op), .i_a(a), .i_b(b),
        .i_abort(abort), .o_ready(ready1), .o_done(done1), .o_hi(hi1),
        .o_lo(lo1), .o_dbz(dbz1)
    );

    uparc_muldiv_engine #(.WIDTH(W), .STEP(4)) dut4 (
        .clk(clk), .rst(rst), .i_start(start4), .i_op(op), .i_a(a), .i_b(b),
        .i_abort(abort), .o_ready(ready4), .o_done(done4), .o_hi(hi4),
        .o_lo(lo4), .o_dbz(dbz4)
    );

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [W-1:0] hi;
        logic [W-1:0] lo;
        logic         dbz;
        int           cyc;
    } exp_t;

    exp_t q1[$];
    exp_t q4[$];
    int checks = 0;
    int failures = 0;
    logic [W-1:0] last_hi, last_lo;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic exp_t model(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
        exp_t e;
        longint sx, sy;
        logic [63:0] p;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        e.dbz = 1'b0;
        e.cyc = 0;
        if (!o[1]) begin
            if (o[0]) p = 64'(sx * sy);
            else      p = {32'd0, x} * {32'd0, y};
            e.hi = p[63:32];
            e.lo = p[31:0];
        end else if (y == 0) begin
            e.hi  = x;
            e.lo  = '1;
            e.dbz = 1'b1;
        end else if (o[0]) begin
            e.lo = 32'(sx / sy);
            e.hi = 32'(sx % sy);
        end else begin
            e.lo = x / y;
            e.hi = x % y;
        end
        return e;
    endfunction

    function automatic int lat(input int unsigned n, input int unsigned step,
                               input logic [1:0] o, input logic [W-1:0] y);
        logic [W-1:0] mb;
        int it;
        bit early;
        mb = (o[0] && y[W-1]) ? -y : y;
        it = 0;
        early = 1'b0;
`ifdef UPARC_MULDIV_EARLY_OUT_EN
        early = 1'b1;
`endif
        if (early && o[1] && y == 0) return 2;
        if (early && !o[1]) begin
            do begin
                it++;
                mb = mb >> step;
            end while (mb != 0 && it < int'(n));
            return it + 2;
        end
        return int'(n) + 2;
    endfunction

    // Scoreboard: every o_done pops one prediction per instance.
    always @(negedge clk) begin
        exp_t e;
        if (done1) begin
            checks++;
            assert (q1.size() != 0) else begin
                failures++;
                $error("FAIL d1_unexpected_done observed=done expected=no_done at cycle %0d", cyc);
            end
            if (q1.size() != 0) begin
                e = q1.pop_front();
                check("d1_hi", hi1, e.hi);
                check("d1_lo", lo1, e.lo);
                check("d1_dbz", dbz1, e.dbz);
                check("d1_done_cycle", cyc, e.cyc);
            end
        end
        if (done4) begin
            checks++;
            assert (q4.size() != 0) else begin
                failures++;
                $error("FAIL d4_unexpected_done observed=done expected=no_done at cycle %0d", cyc);
            end
            if (q4.size() != 0) begin
                e = q4.pop_front();
                check("d4_hi", hi4, e.hi);
                check("d4_lo", lo4, e.lo);
                check("d4_dbz", dbz4, e.dbz);
                check("d4_done_cycle", cyc, e.cyc);
            end
        end
    end

    task automatic push_exp(input bit s1, input bit s4);
        exp_t e;
        e = model(op, a, b);
        last_hi = e.hi;
        last_lo = e.lo;
        if (s1) begin
            e.cyc = cyc + lat(32, 1, op, b);
            q1.push_back(e);
        end
        if (s4) begin
            e.cyc = cyc + lat(8, 4, op, b);
            q4.push_back(e);
        end
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 200 && (q1.size() != 0 || q4.size() != 0); i++) begin
            @(negedge clk);
            #1;
        end
        check("drain_timeout", q1.size() + q4.size(), 0);
    endtask

    task automatic run_op(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
        op = o;
        a = x;
        b = y;
        start1 = 1'b1;
        start4 = 1'b1;
        push_exp(1'b1, 1'b1);
        @(negedge clk);
        #1;
        start1 = 1'b0;
        start4 = 1'b0;
        wait_idle();
    endtask

    initial begin
        int s;
        rst = 1'b1;
        start1 = 1'b0;
        start4 = 1'b0;
        abort = 1'b0;
        op = 2'b00;
        a = '0;
        b = '0;
        repeat (3) @(negedge clk);
        #1;
        check("d1_reset", {ready1, done1, dbz1, hi1, lo1}, {3'b100, 64'd0});
        check("d4_reset", {ready4, done4, dbz4, hi4, lo4}, {3'b100, 64'd0});
        rst = 1'b0;
        @(negedge clk);
        #1;

        run_op(2'b01, 32'hFFFFFFFD, 32'd7);
        run_op(2'b11, 32'hFFFFFFF9, 32'd2);
        run_op(2'b11, 32'h80000000, 32'hFFFFFFFF);
        run_op(2'b10, 32'd100, 32'd0);
        run_op(2'b11, 32'h12345678, 32'd0);
        run_op(2'b01, 32'h80000000, 32'h80000000);
        run_op(2'b00, 32'd5, 32'd3);
        run_op(2'b00, 32'd5, 32'd0);
        run_op(2'b01, 32'h7FFFFFFF, 32'hFFFFFFFF);
        run_op(2'b10, 32'hFFFFFFFF, 32'd3);
        run_op(2'b11, 32'd100, 32'hFFFFFFF9);
        run_op(2'b11, 32'hFFFFFF9C, 32'hFFFFFFF9);
        run_op(2'b10, 32'd3, 32'd100);
        for (int i = 0; i < 4; i++) begin
            run_op(2'(i), $urandom, $urandom);
        end
        for (int i = 0; i < 2; i++) begin
            run_op(2'b11, $urandom, 32'($urandom_range(1, 1000)));
        end

        // Start held high on the STEP=1 instance: second accept only when idle.
        op = 2'b00;
        a = 32'hFFFFFFFF;
        b = 32'hFFFFFFFF;
        start1 = 1'b1;
        start4 = 1'b1;
        s = cyc;
        push_exp(1'b1, 1'b1);
        @(negedge clk);
        #1;
        start4 = 1'b0;
        for (int i = 0; i < 100 && !ready1; i++) begin
            @(negedge clk);
            #1;
        end
        check("held_start_accept_cycle", cyc, s + lat(32, 1, op, b));
        push_exp(1'b1, 1'b0);
        @(negedge clk);
        #1;
        start1 = 1'b0;
        wait_idle();

        // Abort in RUN: no done, results unchanged.
        op = 2'b10;
        a = 32'd1000;
        b = 32'd7;
        start1 = 1'b1;
        start4 = 1'b1;
        s = cyc;
        @(negedge clk);
        #1;
        start1 = 1'b0;
        start4 = 1'b0;
        while (cyc < s + 5) begin
            @(negedge clk);
            #1;
        end
        abort = 1'b1;
        @(negedge clk);
        #1;
        abort = 1'b0;
        @(negedge clk);
        #1;
        check("abort_ready", {ready1, ready4}, 2'b11);
        check("abort_d1_hold", {hi1, lo1}, {last_hi, last_lo});
        check("abort_d4_hold", {hi4, lo4}, {last_hi, last_lo});
        repeat (40) @(negedge clk);
        #1;

        // Reset mid-operation: everything clears, no done.
        start1 = 1'b1;
        start4 = 1'b1;
        s = cyc;
        @(negedge clk);
        #1;
        start1 = 1'b0;
        start4 = 1'b0;
        while (cyc < s + 5) begin
            @(negedge clk);
            #1;
        end
        rst = 1'b1;
        @(negedge clk);
        #1;
        check("d1_mid_reset", {ready1, done1, dbz1, hi1, lo1}, {3'b100, 64'd0});
        check("d4_mid_reset", {ready4, done4, dbz4, hi4, lo4}, {3'b100, 64'd0});
        rst = 1'b0;
        repeat (40) @(negedge clk);
        #1;

        run_op(2'b00, 32'h00001234, 32'h00000010);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
